// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle CPU control FSM (fetch/decode/exec/mem/wb/excp).
// Ports: clk_cpu, reset (async, high); imem/dmem handshakes; decode flags;
//   irq; pc in; datapath enables ir_we/pc_we/rf_we/pc_sel; epc, cause,
//   state (debug), instret (retired count).
module cpu_sequencer #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_cpu,
   input  logic        reset,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        wb_en,
   input  logic        take_branch,
   input  logic        excp,
   input  logic        irq,
   input  logic [31:0] pc,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_we,
   output logic [1:0]  pc_sel,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_EXCP   = 3'd5;

   localparam logic [1:0] C_DEC = 2'd1;
   localparam logic [1:0] C_IRQ = 2'd2;
   localparam logic [1:0] C_BUS = 2'd3;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_TGT = 2'b01;
   localparam logic [1:0] PC_VEC = 2'b10;

   // wait_q counts completed wait cycles, so the last allowed cycle
   // is the one where it equals TIMEOUT-1
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [2:0]  state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic        irq_pend_q, irq_pend_d;
   logic [1:0]  ecause_q, ecause_d;
   logic [31:0] epc_q, epc_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] instret_q, instret_d;

   logic commit;
   logic take_irq;
   logic wait_exp;

   assign wait_exp = (wait_q == WAIT_LAST);

   always_comb begin
      state_d  = state_q;
      ecause_d = ecause_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
      pc_sel   = PC_SEQ;
      commit   = 1'b0;
      take_irq = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (wait_exp) begin
               state_d  = S_EXCP;
               ecause_d = C_BUS;
            end
         end
         S_DECODE: begin
            if (excp) begin
               state_d  = S_EXCP;
               ecause_d = C_DEC;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = (is_load | is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (dmem_ack) begin
               // stores retire on the ack; loads still need writeback
               if (is_store) commit  = 1'b1;
               else          state_d = S_WB;
            end else if (wait_exp) begin
               state_d  = S_EXCP;
               ecause_d = C_BUS;
            end
         end
         S_WB: begin
            commit = 1'b1;
            rf_we  = wb_en;
         end
         S_EXCP: begin
            pc_we   = 1'b1;
            pc_sel  = PC_VEC;
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // the instruction still retires; a pending irq only redirects
      // what follows it
      if (commit) begin
         pc_we  = 1'b1;
         pc_sel = take_branch ? PC_TGT : PC_SEQ;
         if (irq_pend_q) begin
            state_d  = S_EXCP;
            ecause_d = C_IRQ;
            take_irq = 1'b1;
         end else begin
            state_d = S_FETCH;
         end
      end
   end

   always_comb begin
      if (state_d != state_q)
         wait_d = 8'd0;
      else if (state_q == S_FETCH || state_q == S_MEM)
         wait_d = wait_q + 8'd1;
      else
         wait_d = 8'd0;
   end

   // a new irq in the cycle the old one is taken stays pending
   assign irq_pend_d = irq | (irq_pend_q & ~take_irq);
   assign instret_d  = commit ? instret_q + 32'd1 : instret_q;
   assign epc_d      = (state_q == S_EXCP) ? pc : epc_q;
   assign cause_d    = (state_q == S_EXCP) ? ecause_q : cause_q;

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         state_q    <= S_FETCH;
         wait_q     <= 8'd0;
         irq_pend_q <= 1'b0;
         ecause_q   <= 2'd0;
         epc_q      <= 32'd0;
         cause_q    <= 2'd0;
         instret_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         irq_pend_q <= irq_pend_d;
         ecause_q   <= ecause_d;
         epc_q      <= epc_d;
         cause_q    <= cause_d;
         instret_q  <= instret_d;
      end
   end

   assign state   = state_q;
   assign epc     = epc_q;
   assign cause   = cause_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and random instruction streams checked
// cycle by cycle against a per-instruction timing model.
module tb_cpu_sequencer;

   localparam int TO = 16;
   localparam logic [31:0] VEC = 32'h0000_0100;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_EXCP   = 3'd5;

   logic        clk_cpu = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack;
   logic        dmem_req, dmem_we, dmem_ack;
   logic        is_load, is_store, wb_en, take_branch, excp, irq;
   logic [31:0] pc;
   logic        ir_we, pc_we, rf_we;
   logic [1:0]  pc_sel;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic [2:0]  state;
   logic [31:0] instret;

   int total = 0;
   int bad   = 0;

   logic [31:0] pcv, tgt, epc_m, instret_m;
   logic [1:0]  cause_m;
   bit          pend, force_irq, rnd_irq;

   assign pc = pcv;

   always #5 clk_cpu = ~clk_cpu;

   cpu_sequencer #(.TIMEOUT(TO)) dut (
      .clk_cpu(clk_cpu), .reset(reset),
      .imem_req(imem_req), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .is_load(is_load), .is_store(is_store), .wb_en(wb_en),
      .take_branch(take_branch), .excp(excp), .irq(irq), .pc(pc),
      .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .pc_sel(pc_sel),
      .epc(epc), .cause(cause), .state(state), .instret(instret)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock: called at posedge+1 with inputs set, returns at posedge+1
   task automatic step(input logic [2:0] st, input logic ireq,
                       input logic irwe, input logic dreq, input logic dwe,
                       input logic rfwe, input logic pcwe,
                       input logic [1:0] psel, input bit clr);
      irq = force_irq | (rnd_irq && ($urandom_range(0, 11) == 0));
      force_irq = 1'b0;
      #2;
      chk("state",    32'(state),    32'(st));
      chk("imem_req", 32'(imem_req), 32'(ireq));
      chk("ir_we",    32'(ir_we),    32'(irwe));
      chk("dmem_req", 32'(dmem_req), 32'(dreq));
      chk("dmem_we",  32'(dmem_we),  32'(dwe));
      chk("rf_we",    32'(rf_we),    32'(rfwe));
      chk("pc_we",    32'(pc_we),    32'(pcwe));
      chk("pc_sel",   32'(pc_sel),   32'(psel));
      @(posedge clk_cpu);
      pend = clr ? irq : (pend | irq);
      #1;
      irq = 1'b0;
   endtask

   task automatic excp_cyc(input logic [1:0] c);
      step(S_EXCP, 0, 0, 0, 0, 0, 1, 2'b10, 0);
      epc_m   = pcv;
      cause_m = c;
      pcv     = VEC;
      chk("epc",       epc,          epc_m);
      chk("cause",     32'(cause),   32'(cause_m));
      chk("instret_x", instret,      instret_m);
   endtask

   task automatic commit_cyc(input logic [2:0] st, input logic dreq,
                             input logic dwe, input logic rfwe,
                             input bit br);
      bit c;
      c = pend;
      step(st, 0, 0, dreq, dwe, rfwe, 1, br ? 2'b01 : 2'b00, c);
      instret_m++;
      pcv = br ? tgt : pcv + 32'd4;
      chk("instret", instret, instret_m);
      if (c) excp_cyc(2'd2);
   endtask

   // kind: 0 alu, 1 load, 2 store; fw/mw = wait cycles before ack
   // (>= TO means never acked); irq_ph: 1 pulse in first FETCH cycle,
   // 2 pulse in first MEM cycle
   task automatic run_instr(input int fw, input int kind, input bit dx,
                            input int mw, input bit wb, input bit br,
                            input int irq_ph);
      tgt         = $urandom & 32'hFFFF_FFFC;
      is_load     = (kind == 1);
      is_store    = (kind == 2);
      wb_en       = wb;
      take_branch = br;
      excp        = dx;
      for (int k = 0; k < TO; k++) begin
         imem_ack = (k == fw);
         dmem_ack = 1'($urandom_range(0, 1));
         if (k == 0 && irq_ph == 1) force_irq = 1'b1;
         step(S_FETCH, 1, (k == fw), 0, 0, 0, 0, 2'b00, 0);
         if (k == fw) break;
         if (k == TO - 1) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            excp_cyc(2'd3);
            return;
         end
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      step(S_DECODE, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      if (dx) begin
         excp_cyc(2'd1);
         return;
      end
      step(S_EXEC, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      if (kind == 0) begin
         commit_cyc(S_WB, 0, 0, wb, br);
         return;
      end
      for (int k = 0; k < TO; k++) begin
         dmem_ack = (k == mw);
         imem_ack = 1'($urandom_range(0, 1));
         if (k == 0 && irq_ph == 2) force_irq = 1'b1;
         if (k == mw && kind == 2) begin
            commit_cyc(S_MEM, 1, 1, 0, br);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            return;
         end
         step(S_MEM, 0, 0, 1, (kind == 2), 0, 0, 2'b00, 0);
         if (k == mw) break;
         if (k == TO - 1) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            excp_cyc(2'd3);
            return;
         end
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      commit_cyc(S_WB, 0, 0, wb, br);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      imem_ack = 0; dmem_ack = 0; is_load = 0; is_store = 0;
      wb_en = 0; take_branch = 0; excp = 0; irq = 0;
      pcv = 32'h0000_1000; tgt = 0;
      pend = 0; force_irq = 0; rnd_irq = 0;
      epc_m = 0; cause_m = 0; instret_m = 0;
      #1;
      chk("rst_state",   32'(state),   32'(S_FETCH));
      chk("rst_instret", instret,      32'd0);
      chk("rst_epc",     epc,          32'd0);
      chk("rst_cause",   32'(cause),   32'd0);
      @(posedge clk_cpu);
      @(posedge clk_cpu);
      #1 reset = 1'b0;

      // alu, two fetch waits: 6 cycles fetch to fetch
      run_instr(2, 0, 0, 0, 1, 0, 0);
      // load acked first MEM cycle, then store
      run_instr(0, 1, 0, 0, 1, 0, 0);
      run_instr(1, 2, 0, 0, 1, 0, 0);
      chk("instret_ld_st", instret, 32'd3);
      // fetch timeout, then ack on the last allowed cycle
      run_instr(40, 0, 0, 0, 1, 0, 0);
      run_instr(TO - 1, 0, 0, 0, 1, 0, 0);
      // data timeout
      run_instr(0, 1, 0, 40, 1, 0, 0);
      // irq during MEM of a branching load; epc is the target
      run_instr(0, 1, 0, 2, 1, 1, 2);
      chk("epc_tgt", epc, tgt);
      run_instr(0, 0, 0, 0, 0, 0, 0);
      // decode exception beats pending irq; irq taken after next instr
      run_instr(0, 0, 0, 0, 1, 0, 1);
      run_instr(0, 0, 1, 0, 1, 0, 1);
      run_instr(3, 0, 0, 0, 1, 0, 0);
      chk("cause_irq_after", 32'(cause), 32'd2);

      // reset in the middle of a MEM wait
      is_load = 1; is_store = 0; excp = 0;
      imem_ack = 1;
      step(S_FETCH, 1, 1, 0, 0, 0, 0, 2'b00, 0);
      imem_ack = 0;
      step(S_DECODE, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      step(S_EXEC, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      #1;
      chk("mem_req_before", 32'(dmem_req), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst2_state",   32'(state),    32'(S_FETCH));
      chk("rst2_instret", instret,       32'd0);
      chk("rst2_epc",     epc,           32'd0);
      chk("rst2_cause",   32'(cause),    32'd0);
      @(posedge clk_cpu);
      #1 reset = 1'b0;
      pend = 0; instret_m = 0; epc_m = 0; cause_m = 0;
      #1;
      chk("rel_imem_req", 32'(imem_req), 32'd1);
      @(posedge clk_cpu);
      #1;
      chk("rel_state", 32'(state), 32'(S_FETCH));

      // random stream with random irq
      rnd_irq = 1;
      for (int n = 0; n < 60; n++) begin
         run_instr($urandom_range(0, 18), $urandom_range(0, 2),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 18),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
      rnd_irq = 0;
      run_instr(0, 0, 0, 0, 1, 0, 0);
      if (pend) excp_cyc(2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
